// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU op classes, the zero register, and the
// control-bundle layout used by every inter-stage pipeline register.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control-bundle bit positions
  localparam int unsigned CTL_REG_WRITE  = 0;
  localparam int unsigned CTL_MEM_READ   = 1;
  localparam int unsigned CTL_MEM_WRITE  = 2;
  localparam int unsigned CTL_MEM_TO_REG = 3;
  localparam int unsigned CTL_ALU_SRC    = 4;
  localparam int unsigned CTL_ALU_OP_LSB = 5;
  localparam int unsigned CTL_W          = 7;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds the
// instruction in ID cannot be forwarded in time, so ID must stall one cycle.
// A branch flush overrides the stall so the redirect can proceed.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             mem_read_EX,
  input  logic [REG_W-1:0] reg_Rt_EX,
  input  logic [REG_W-1:0] reg_Rs_ID,
  input  logic [REG_W-1:0] reg_Rt_ID,
  input  logic             flush_EX,
  output logic             hazard,
  output logic             stall_ID
);

  // Compare the load destination against both ID sources; $0 never hazards
  always_comb begin
    hazard   = mem_read_EX
             & (reg_Rt_EX != REG_W'(REG_ZERO))
             & ((reg_Rt_EX == reg_Rs_ID) | (reg_Rt_EX == reg_Rt_ID));
    stall_ID = hazard & ~flush_EX;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// count of hazard bubbles. A bubble is all-zero, including register numbers,
// so forwarding and hazard compares can never match on it.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  reg_Rs_ID,
  input  logic [REG_W-1:0]  reg_Rt_ID,
  input  logic [REG_W-1:0]  reg_Rd_ID,
  input  logic [DATA_W-1:0] read_data1_ID,
  input  logic [DATA_W-1:0] read_data2_ID,
  input  logic [DATA_W-1:0] imm_ID,
  input  logic              reg_write_ID,
  input  logic              mem_read_ID,
  input  logic              mem_write_ID,
  input  logic              mem_to_reg_ID,
  input  logic              alu_src_ID,
  input  logic              reg_dst_ID,
  input  logic [1:0]        alu_op_ID,
  input  logic              flush_EX,
  output logic [REG_W-1:0]  reg_Rs_EX,
  output logic [REG_W-1:0]  reg_Rt_EX,
  output logic [REG_W-1:0]  reg_Rd_EX,
  output logic [DATA_W-1:0] read_data1_EX,
  output logic [DATA_W-1:0] read_data2_EX,
  output logic [DATA_W-1:0] imm_EX,
  output logic              reg_write_EX,
  output logic              mem_read_EX,
  output logic              mem_write_EX,
  output logic              mem_to_reg_EX,
  output logic              alu_src_EX,
  output logic [1:0]        alu_op_EX,
  output logic              stall_ID,
  output logic [CNT_W-1:0]  stall_count
);

  logic [REG_W-1:0]  r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_d1, r_d2, r_imm;
  logic [CTL_W-1:0]  r_ctl;
  logic [CNT_W-1:0]  r_cnt;

  logic [CTL_W-1:0]  w_ctl_id;
  logic [REG_W-1:0]  w_rd_id;
  logic              w_hazard;
  logic              w_stall;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .mem_read_EX (r_ctl[CTL_MEM_READ]),
    .reg_Rt_EX   (r_rt),
    .reg_Rs_ID   (reg_Rs_ID),
    .reg_Rt_ID   (reg_Rt_ID),
    .flush_EX    (flush_EX),
    .hazard      (w_hazard),
    .stall_ID    (w_stall)
  );

  // Pack ID control into the shared bundle layout and resolve the destination
  always_comb begin
    w_ctl_id                       = '0;
    w_ctl_id[CTL_REG_WRITE]        = reg_write_ID;
    w_ctl_id[CTL_MEM_READ]         = mem_read_ID;
    w_ctl_id[CTL_MEM_WRITE]        = mem_write_ID;
    w_ctl_id[CTL_MEM_TO_REG]       = mem_to_reg_ID;
    w_ctl_id[CTL_ALU_SRC]          = alu_src_ID;
    w_ctl_id[CTL_ALU_OP_LSB +: 2]  = alu_op_ID;
    w_rd_id                        = reg_dst_ID ? reg_Rd_ID : reg_Rt_ID;
  end

  // Pipeline register: flush beats hazard beats capture; only hazard bubbles are counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs  <= '0;
      r_rt  <= '0;
      r_rd  <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
      r_imm <= '0;
      r_ctl <= '0;
      r_cnt <= '0;
    end else if (flush_EX || w_hazard) begin
      r_rs  <= '0;
      r_rt  <= '0;
      r_rd  <= '0;
      r_d1  <= '0;
      r_d2  <= '0;
      r_imm <= '0;
      r_ctl <= '0;
      if (!flush_EX && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_rs  <= reg_Rs_ID;
      r_rt  <= reg_Rt_ID;
      r_rd  <= w_rd_id;
      r_d1  <= read_data1_ID;
      r_d2  <= read_data2_ID;
      r_imm <= imm_ID;
      r_ctl <= w_ctl_id;
    end
  end

  assign reg_Rs_EX     = r_rs;
  assign reg_Rt_EX     = r_rt;
  assign reg_Rd_EX     = r_rd;
  assign read_data1_EX = r_d1;
  assign read_data2_EX = r_d2;
  assign imm_EX        = r_imm;
  assign reg_write_EX  = r_ctl[CTL_REG_WRITE];
  assign mem_read_EX   = r_ctl[CTL_MEM_READ];
  assign mem_write_EX  = r_ctl[CTL_MEM_WRITE];
  assign mem_to_reg_EX = r_ctl[CTL_MEM_TO_REG];
  assign alu_src_EX    = r_ctl[CTL_ALU_SRC];
  assign alu_op_EX     = r_ctl[CTL_ALU_OP_LSB +: 2];
  assign stall_ID      = w_stall;
  assign stall_count   = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of ID instructions with expected stall and EX
// results, checked through a scoreboard queue, plus reset sequences.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_W-1:0]  reg_Rs_ID, reg_Rt_ID, reg_Rd_ID;
  logic [DATA_W-1:0] read_data1_ID, read_data2_ID, imm_ID;
  logic              reg_write_ID, mem_read_ID, mem_write_ID, mem_to_reg_ID, alu_src_ID, reg_dst_ID;
  logic [1:0]        alu_op_ID;
  logic              flush_EX;
  logic [REG_W-1:0]  reg_Rs_EX, reg_Rt_EX, reg_Rd_EX;
  logic [DATA_W-1:0] read_data1_EX, read_data2_EX, imm_EX;
  logic              reg_write_EX, mem_read_EX, mem_write_EX, mem_to_reg_EX, alu_src_EX;
  logic [1:0]        alu_op_EX;
  logic              stall_ID;
  logic [CNT_W-1:0]  stall_count;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .reg_Rs_ID(reg_Rs_ID), .reg_Rt_ID(reg_Rt_ID), .reg_Rd_ID(reg_Rd_ID),
    .read_data1_ID(read_data1_ID), .read_data2_ID(read_data2_ID), .imm_ID(imm_ID),
    .reg_write_ID(reg_write_ID), .mem_read_ID(mem_read_ID), .mem_write_ID(mem_write_ID),
    .mem_to_reg_ID(mem_to_reg_ID), .alu_src_ID(alu_src_ID), .reg_dst_ID(reg_dst_ID),
    .alu_op_ID(alu_op_ID), .flush_EX(flush_EX),
    .reg_Rs_EX(reg_Rs_EX), .reg_Rt_EX(reg_Rt_EX), .reg_Rd_EX(reg_Rd_EX),
    .read_data1_EX(read_data1_EX), .read_data2_EX(read_data2_EX), .imm_EX(imm_EX),
    .reg_write_EX(reg_write_EX), .mem_read_EX(mem_read_EX), .mem_write_EX(mem_write_EX),
    .mem_to_reg_EX(mem_to_reg_EX), .alu_src_EX(alu_src_EX), .alu_op_EX(alu_op_EX),
    .stall_ID(stall_ID), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       rdst, rw, mr, mw;
    logic [1:0] aop;
    logic       flush;
    logic       exp_stall;
    logic       exp_bubble;
    logic [4:0] exp_rd;
    logic [1:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [4:0]  ctl;
    logic [1:0]  aop;
    logic [95:0] data;
    logic [1:0]  cnt;
  } exp_t;

  vec_t tv[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic rdst,
                              logic rw, logic mr, logic mw, logic [1:0] aop, logic flush,
                              logic exp_stall, logic exp_bubble, logic [4:0] exp_rd,
                              logic [1:0] exp_cnt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd; v.rdst = rdst; v.rw = rw; v.mr = mr; v.mw = mw;
    v.aop = aop; v.flush = flush; v.exp_stall = exp_stall; v.exp_bubble = exp_bubble;
    v.exp_rd = exp_rd; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  function automatic logic [95:0] data_for(int idx);
    logic [31:0] d1, d2, im;
    d1 = 32'h1000_0000 + 32'(idx);
    d2 = 32'h2000_0000 + 32'(idx * 3);
    im = 32'hFFFF_0000 | 32'(idx);
    return {d1, d2, im};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v, input int idx);
    logic [95:0] d;
    d = data_for(idx);
    reg_Rs_ID = v.rs; reg_Rt_ID = v.rt; reg_Rd_ID = v.rd;
    {read_data1_ID, read_data2_ID, imm_ID} = d;
    reg_write_ID = v.rw; mem_read_ID = v.mr; mem_write_ID = v.mw;
    mem_to_reg_ID = v.mr; alu_src_ID = v.mr | v.mw; reg_dst_ID = v.rdst;
    alu_op_ID = v.aop; flush_EX = v.flush;
  endtask

  task automatic push_exp(input vec_t v, input int idx);
    exp_t e;
    if (v.exp_bubble) begin
      e.rs = '0; e.rt = '0; e.rd = '0; e.ctl = '0; e.aop = '0; e.data = '0;
    end else begin
      e.rs = v.rs; e.rt = v.rt; e.rd = v.exp_rd;
      e.ctl = {v.rw, v.mr, v.mw, v.mr, v.mr | v.mw};
      e.aop = v.aop; e.data = data_for(idx);
    end
    e.cnt = v.exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " rs"},  96'(reg_Rs_EX), 96'(e.rs));
      check({tag, " rt"},  96'(reg_Rt_EX), 96'(e.rt));
      check({tag, " rd"},  96'(reg_Rd_EX), 96'(e.rd));
      check({tag, " ctl"}, 96'({reg_write_EX, mem_read_EX, mem_write_EX, mem_to_reg_EX, alu_src_EX}), 96'(e.ctl));
      check({tag, " aluop"}, 96'(alu_op_EX), 96'(e.aop));
      check({tag, " data"}, {read_data1_EX, read_data2_EX, imm_EX}, e.data);
      check({tag, " count"}, 96'(stall_count), 96'(e.cnt));
    end
  endtask

  task automatic check_zero(input string tag, input logic [1:0] cnt);
    check({tag, " stall"}, 96'(stall_ID), 96'(0));
    check({tag, " regs"}, 96'({reg_Rs_EX, reg_Rt_EX, reg_Rd_EX}), 96'(0));
    check({tag, " ctl"}, 96'({reg_write_EX, mem_read_EX, mem_write_EX, mem_to_reg_EX, alu_src_EX, alu_op_EX}), 96'(0));
    check({tag, " data"}, {read_data1_EX, read_data2_EX, imm_EX}, 96'(0));
    check({tag, " count"}, 96'(stall_count), 96'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //       rs  rt  rd rdst rw mr mw aop        fl  stall bub rd  cnt
    tv.push_back(mk(1, 2, 3, 1, 1, 0, 0, ALU_RTYPE, 0, 0, 0, 3, 0)); // add $3,$1,$2
    tv.push_back(mk(1, 5, 0, 0, 1, 1, 0, ALU_ADD,   0, 0, 0, 5, 0)); // lw $5
    tv.push_back(mk(5, 7, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 1, 1, 0, 1)); // add $6,$5,$7 stalls
    tv.push_back(mk(5, 7, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 0, 0, 6, 1)); // held add captured
    tv.push_back(mk(1, 0, 0, 0, 1, 1, 0, ALU_ADD,   0, 0, 0, 0, 1)); // lw $0
    tv.push_back(mk(0, 7, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 0, 0, 6, 1)); // add $6,$0,$7 no hazard
    tv.push_back(mk(1, 5, 0, 0, 1, 1, 0, ALU_ADD,   0, 0, 0, 5, 1)); // lw $5
    tv.push_back(mk(8, 9, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 0, 0, 6, 1)); // add $6,$8,$9 no hazard
    tv.push_back(mk(1, 5, 0, 0, 1, 1, 0, ALU_ADD,   0, 0, 0, 5, 1)); // lw $5
    tv.push_back(mk(7, 5, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 1, 1, 0, 2)); // rt dependency stalls
    tv.push_back(mk(7, 5, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 0, 0, 6, 2));
    tv.push_back(mk(1, 5, 0, 0, 1, 1, 0, ALU_ADD,   0, 0, 0, 5, 2)); // lw $5
    tv.push_back(mk(5, 7, 6, 1, 1, 0, 0, ALU_RTYPE, 1, 0, 1, 0, 2)); // flush beats hazard
    tv.push_back(mk(2, 3, 4, 1, 1, 0, 0, ALU_SUB,   0, 0, 0, 4, 2)); // sub $4,$2,$3
    tv.push_back(mk(1, 2, 9, 1, 1, 0, 0, ALU_RTYPE, 1, 0, 1, 0, 2)); // plain flush
    for (int k = 0; k < 3; k++) begin
      tv.push_back(mk(1, 5, 0, 0, 1, 1, 0, ALU_ADD,   0, 0, 0, 5, 2'(k == 0 ? 2 : 3)));
      tv.push_back(mk(5, 7, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 1, 1, 0, 3)); // saturates at 3
      tv.push_back(mk(5, 7, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 0, 0, 6, 3));
    end
    tv.push_back(mk(1, 5, 0, 0, 0, 0, 1, ALU_ADD,   0, 0, 0, 5, 3)); // sw $5

    // Reset with arbitrary ID inputs, including a would-be hazard pattern
    reset = 1'b0;
    drive(mk(5, 5, 5, 0, 1, 1, 1, ALU_SUB, 0, 0, 0, 0, 0), 99);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset", 2'd0);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i], i);
      #1;
      check($sformatf("vec%0d stall", i), 96'(stall_ID), 96'(tv[i].exp_stall));
      push_exp(tv[i], i);
      @(posedge clk);
      #1;
      check_pop($sformatf("vec%0d", i));
    end

    // Async reset while a load-use stall is pending
    drive(mk(1, 5, 0, 0, 1, 1, 0, ALU_ADD, 0, 0, 0, 5, 3), 50);
    push_exp(mk(1, 5, 0, 0, 1, 1, 0, ALU_ADD, 0, 0, 0, 5, 3), 50);
    @(posedge clk);
    #1;
    check_pop("mid lw");
    drive(mk(5, 7, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 0, 0, 6, 0), 51);
    #1;
    check("mid stall before reset", 96'(stall_ID), 96'(1));
    reset = 1'b0;
    #1;
    check_zero("mid reset immediate", 2'd0);
    @(posedge clk);
    #1;
    check_zero("mid reset held", 2'd0);
    reset = 1'b1;
    #1;
    check("after reset stall", 96'(stall_ID), 96'(0));
    push_exp(mk(5, 7, 6, 1, 1, 0, 0, ALU_RTYPE, 0, 0, 0, 6, 0), 51);
    @(posedge clk);
    #1;
    check_pop("after reset capture");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
